// File: rtl/nrisc_fetch.sv
// NRISC instruction fetch stage: owns the PC and a hardware call/return stack,
// fetches 16-bit words over a req/ack memory port and hands them to the core.
module nrisc_fetch #(
    parameter int             TAM         = 16,
    parameter int             STACK_DEPTH = 8,
    parameter logic [TAM-1:0] RESET_PC    = '0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [1:0]     FETCH_PC_ctrl,
    input  logic [TAM-1:0] FETCH_PC_target,
    input  logic           FETCH_ready,
    output logic [15:0]    FETCH_instr,
    output logic           FETCH_valid,
    output logic [TAM-1:0] FETCH_PC,
    output logic [TAM-1:0] IMEM_addr,
    output logic           IMEM_req,
    input  logic           IMEM_ack,
    input  logic [15:0]    IMEM_data,
    output logic           STACK_empty,
    output logic           STACK_full,
    output logic           STACK_err
);

    localparam int             SPW     = $clog2(STACK_DEPTH) + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [TAM-1:0] r_pc;
    logic [TAM-1:0] w_nextPc;
    logic [TAM-1:0] w_pcInc;
    logic [SPW-1:0] r_sp;
    logic [SPW-1:0] w_nextSp;
    logic [SPW-1:0] w_spInc;
    logic [SPW-1:0] w_spDec;
    logic [TAM-1:0] r_stack [STACK_DEPTH];
    logic [15:0]    r_instr;
    logic           r_err;
    logic           w_nextErr;
    logic           w_push;
    logic           w_accept;
    logic           w_empty;
    logic           w_full;

    assign w_pcInc  = r_pc + TAM'(1);
    assign w_spInc  = r_sp + SPW'(1);
    assign w_spDec  = r_sp - SPW'(1);
    assign w_empty  = (r_sp == '0);
    assign w_full   = (r_sp == SP_FULL);
    assign w_accept = (r_state == S_HOLD) && FETCH_ready;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:  w_nextState = S_FETCH;
            S_FETCH: if (IMEM_ack) w_nextState = S_HOLD;
            S_HOLD:  if (FETCH_ready) w_nextState = S_FETCH;
            default: w_nextState = S_IDLE;
        endcase
    end

    // A call on a full stack or a return on an empty one degrades to a plain
    // increment and raises the sticky error flag instead of corrupting sp.
    always_comb begin
        w_nextPc  = r_pc;
        w_nextSp  = r_sp;
        w_nextErr = r_err;
        w_push    = 1'b0;
        if (w_accept) begin
            case (FETCH_PC_ctrl)
                2'b00: w_nextPc = w_pcInc;
                2'b01: w_nextPc = FETCH_PC_target;
                2'b10: begin
                    if (!w_full) begin
                        w_push   = 1'b1;
                        w_nextSp = w_spInc;
                        w_nextPc = FETCH_PC_target;
                    end else begin
                        w_nextPc  = w_pcInc;
                        w_nextErr = 1'b1;
                    end
                end
                2'b11: begin
                    if (!w_empty) begin
                        w_nextSp = w_spDec;
                        w_nextPc = r_stack[w_spDec[SPW-2:0]];
                    end else begin
                        w_nextPc  = w_pcInc;
                        w_nextErr = 1'b1;
                    end
                end
                default: w_nextPc = r_pc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_sp    <= '0;
            r_instr <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_pc    <= w_nextPc;
            r_sp    <= w_nextSp;
            r_err   <= w_nextErr;
            if (r_state == S_FETCH && IMEM_ack) begin
                r_instr <= IMEM_data;
            end
        end
    end

    // Stack storage has no reset; clearing sp alone empties it logically.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_stack[r_sp[SPW-2:0]] <= w_pcInc;
        end
    end

    assign FETCH_instr = r_instr;
    assign FETCH_valid = (r_state == S_HOLD);
    assign IMEM_req    = (r_state == S_FETCH);
    assign FETCH_PC    = r_pc;
    assign IMEM_addr   = r_pc;
    assign STACK_empty = w_empty;
    assign STACK_full  = w_full;
    assign STACK_err   = r_err;

endmodule
